// File: rtl/maze_tile_arbiter.sv
// maze_tile_arbiter: shares the maze tile RAM port between video and game readers, clears eaten pellets, counts pellets left.
module maze_tile_arbiter #(
  parameter int COLS = 20,
  parameter int ROWS = 40,
  parameter int PELLET_TOTAL = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vid_req,
  input  logic [9:0] vid_x,
  input  logic [9:0] vid_y,
  output logic       vid_valid,
  output logic [1:0] vid_tile,
  input  logic       pac_req,
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  input  logic       pac_eat,
  output logic       pac_gnt,
  output logic       pac_done,
  output logic [1:0] pac_tile,
  input  logic       ghost_req,
  input  logic [9:0] ghost_x,
  input  logic [9:0] ghost_y,
  output logic       ghost_gnt,
  output logic       ghost_done,
  output logic [1:0] ghost_tile,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [1:0] ram_wdata,
  input  logic [1:0] ram_rdata,
  input  logic       level_start,
  output logic [9:0] pellets_left,
  output logic       pellet_eaten,
  output logic       power_eaten,
  output logic       level_clear
);
  typedef enum logic [1:0] {IDLE, WAIT, WB, DONE} state_t;
  state_t state, state_n;
  logic sel, last_g, vid_oob, pick_g, cur_g, start, write, g_oob;
  logic [9:0] gx, gy, g_addr;
  logic [1:0] captured;
  function automatic logic [9:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
    return 10'(y[9:3]) * 10'(COLS) + 10'(x[9:3]);
  endfunction
  function automatic logic off_grid(input logic [9:0] x, input logic [9:0] y);
    return x >= 10'(8 * COLS) || y >= 10'(8 * ROWS);
  endfunction
  // game requesters hold their inputs until done, so the live inputs of the selected port stay valid all transaction
  assign pick_g = ghost_req & (~pac_req | ~last_g);
  assign cur_g = state == IDLE ? pick_g : sel;
  assign gx = cur_g ? ghost_x : pac_x;
  assign gy = cur_g ? ghost_y : pac_y;
  assign g_addr = tile_addr(gx, gy);
  assign g_oob = off_grid(gx, gy);
  assign start = !rst && state == IDLE && !vid_req && (pac_req || ghost_req);
  assign write = !rst && state == WB && !vid_req;
  assign captured = g_oob ? 2'b01 : ram_rdata;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? WAIT : IDLE;
      WAIT: state_n = (!sel && pac_eat && captured[1]) ? WB : DONE;
      WB:   state_n = vid_req ? WB : DONE;
      default: state_n = IDLE;
    endcase
  end
  assign ram_we = write;
  assign ram_wdata = 2'b00;
  assign ram_addr = rst ? '0 : vid_req ? tile_addr(vid_x, vid_y) : ((start && !g_oob) || write) ? g_addr : '0;
  assign pac_gnt = start && !pick_g;
  assign ghost_gnt = start && pick_g;
  assign pac_done = !rst && state == DONE && !sel;
  assign ghost_done = !rst && state == DONE && sel;
  assign pellet_eaten = write && !pac_tile[0];
  assign power_eaten = write && pac_tile[0];
  assign vid_tile = (vid_valid && !vid_oob) ? ram_rdata : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= 1'b0;
      last_g <= 1'b1;
      vid_valid <= 1'b0;
      vid_oob <= 1'b0;
      pac_tile <= 2'b00;
      ghost_tile <= 2'b00;
      pellets_left <= 10'(PELLET_TOTAL);
      level_clear <= PELLET_TOTAL == 0;
    end else begin
      state <= state_n;
      vid_valid <= vid_req;
      vid_oob <= off_grid(vid_x, vid_y);
      if (start) begin
        sel <= pick_g;
        last_g <= pick_g;
      end
      if (state == WAIT && !sel) pac_tile <= captured;
      if (state == WAIT && sel) ghost_tile <= captured;
      pellets_left <= level_start ? 10'(PELLET_TOTAL) : (write && pellets_left != 0) ? pellets_left - 10'd1 : pellets_left;
      level_clear <= pellets_left == 0;
    end
  end
endmodule

// File: tb/tb_maze_tile_arbiter.sv
// tb_maze_tile_arbiter: directed vector table plus hand sequences for arbitration, video stalls, counter bounds and reset.
module tb_maze_tile_arbiter;
  logic clk = 0, rst = 1, load = 1;
  always #5 clk = ~clk;
  logic vid_req = 0, pac_req = 0, pac_eat = 0, ghost_req = 0, level_start = 0;
  logic [9:0] vid_x = 0, vid_y = 0, pac_x = 0, pac_y = 0, ghost_x = 0, ghost_y = 0;
  logic vid_valid, pac_gnt, pac_done, ghost_gnt, ghost_done, ram_we, pellet_eaten, power_eaten, level_clear;
  logic [1:0] vid_tile, pac_tile, ghost_tile, ram_wdata, ram_rdata;
  logic [9:0] ram_addr, pellets_left;
  logic b_vid_valid, b_pac_gnt, b_pac_done, b_ghost_gnt, b_ghost_done, b_ram_we, b_pellet_eaten, b_power_eaten, b_level_clear;
  logic [1:0] b_vid_tile, b_pac_tile, b_ghost_tile, b_ram_wdata;
  logic [9:0] b_ram_addr, b_pellets_left;
  logic [1:0] mem [1024];
  int checks = 0, failures = 0, cnum = 0, we_cnt = 0, pe_cnt = 0, pw_cnt = 0;
  logic [9:0] we_addr = 0;

  maze_tile_arbiter u1 (
    .clk(clk), .rst(rst), .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y), .vid_valid(vid_valid), .vid_tile(vid_tile),
    .pac_req(pac_req), .pac_x(pac_x), .pac_y(pac_y), .pac_eat(pac_eat), .pac_gnt(pac_gnt), .pac_done(pac_done), .pac_tile(pac_tile),
    .ghost_req(ghost_req), .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_gnt(ghost_gnt), .ghost_done(ghost_done), .ghost_tile(ghost_tile),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .level_start(level_start), .pellets_left(pellets_left), .pellet_eaten(pellet_eaten), .power_eaten(power_eaten), .level_clear(level_clear));

  // same stimulus and RAM data, small pellet total for the counter bounds
  maze_tile_arbiter #(.PELLET_TOTAL(2)) u2 (
    .clk(clk), .rst(rst), .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y), .vid_valid(b_vid_valid), .vid_tile(b_vid_tile),
    .pac_req(pac_req), .pac_x(pac_x), .pac_y(pac_y), .pac_eat(pac_eat), .pac_gnt(b_pac_gnt), .pac_done(b_pac_done), .pac_tile(b_pac_tile),
    .ghost_req(ghost_req), .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_gnt(b_ghost_gnt), .ghost_done(b_ghost_done), .ghost_tile(b_ghost_tile),
    .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(ram_rdata),
    .level_start(level_start), .pellets_left(b_pellets_left), .pellet_eaten(b_pellet_eaten), .power_eaten(b_power_eaten), .level_clear(b_level_clear));

  function automatic logic [1:0] init_val(input int a);
    case (a)
      101, 800: return 2'b01;
      22, 799, 200, 202, 203, 204: return 2'b10;
      45, 46, 201: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    cnum <= cnum + 1;
  end

  always @(negedge clk) begin
    if (ram_we) begin we_cnt++; we_addr = ram_addr; end
    if (pellet_eaten) pe_cnt++;
    if (power_eaten) pw_cnt++;
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic pac_txn(input logic [9:0] x, input logic [9:0] y, input logic e,
                         output int lat, output logic [1:0] tile, output logic [9:0] gaddr);
    int g_c, d_c;
    bit got;
    @(posedge clk); #1;
    pac_x = x; pac_y = y; pac_eat = e; pac_req = 1;
    got = 0; g_c = -100; d_c = 0; gaddr = 0; tile = 2'bxx;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (pac_gnt) begin g_c = cnum; gaddr = ram_addr; end
      if (pac_done) begin got = 1; d_c = cnum; tile = pac_tile; end
    end
    @(posedge clk); #1;
    pac_req = 0; pac_eat = 0;
    lat = got ? d_c - g_c : -1;
  endtask

  typedef struct {
    logic [9:0] x, y;
    logic eat, in_grid;
    int addr, tile, lat, wr, pe, pw;
  } vec_t;
  vec_t vt [9];

  initial begin
    int lat, w0, p0, q0, ng, ok;
    int gs [4], gc [4];
    logic [1:0] tile, pt, gt;
    logic [9:0] ga;
    vt[0] = '{10'd8,   10'd40,  1'b0, 1'b1, 101, 1, 2, 0, 0, 0};
    vt[1] = '{10'd16,  10'd8,   1'b1, 1'b1, 22,  2, 3, 1, 1, 0};
    vt[2] = '{10'd16,  10'd8,   1'b0, 1'b1, 22,  0, 2, 0, 0, 0};
    vt[3] = '{10'd55,  10'd23,  1'b1, 1'b1, 46,  3, 3, 1, 0, 1};
    vt[4] = '{10'd160, 10'd0,   1'b1, 1'b0, 0,   1, 2, 0, 0, 0};
    vt[5] = '{10'd0,   10'd320, 1'b0, 1'b0, 0,   1, 2, 0, 0, 0};
    vt[6] = '{10'd159, 10'd319, 1'b0, 1'b1, 799, 2, 2, 0, 0, 0};
    vt[7] = '{10'd159, 10'd319, 1'b1, 1'b1, 799, 2, 3, 1, 1, 0};
    vt[8] = '{10'd7,   10'd7,   1'b1, 1'b1, 0,   0, 2, 0, 0, 0};

    // reset: during and after two reset cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pellets", pellets_left, 300);
    chk("rst_we", ram_we, 0);
    @(posedge clk); #1 rst = 0; load = 0;
    @(negedge clk);
    chk("rst_outs", {vid_valid, pac_gnt, pac_done, ghost_gnt, ghost_done, pellet_eaten, power_eaten, ram_we}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_tiles", {pac_tile, ghost_tile}, 0);
    chk("rst_pellets_after", pellets_left, 300);
    chk("rst_clear", level_clear, 0);
    chk("rst_b_pellets", b_pellets_left, 2);
    chk("rst_no_write", we_cnt, 0);

    // both requesters held: alternate starting with Pac-Man, one grant every 3 cycles
    w0 = we_cnt;
    gs = '{-1, -1, -1, -1}; gc = '{0, 0, 0, 0}; pt = 2'bxx; gt = 2'bxx;
    @(posedge clk); #1;
    pac_x = 8; pac_y = 40; ghost_x = 16; ghost_y = 8; pac_req = 1; ghost_req = 1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (pac_gnt) begin gs[ng] = 0; gc[ng] = cnum; ng++; end
      else if (ghost_gnt) begin gs[ng] = 1; gc[ng] = cnum; ng++; end
      if (pac_done) pt = pac_tile;
      if (ghost_done) gt = ghost_tile;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ghost_done) begin gt = ghost_tile; break; end
    end
    @(posedge clk); #1 pac_req = 0; ghost_req = 0;
    chk("arb_order", {gs[0][1:0], gs[1][1:0], gs[2][1:0], gs[3][1:0]}, 8'b00_01_00_01);
    chk("arb_spacing", gc[3] - gc[0], 9);
    chk("arb_pac_tile", pt, 1);
    chk("arb_ghost_tile", gt, 2);
    chk("arb_no_write", we_cnt - w0, 0);

    // video held 4 cycles over a pending Pac-Man request
    @(posedge clk); #1;
    vid_req = 1; vid_x = 16; vid_y = 8; pac_x = 8; pac_y = 40; pac_req = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk($sformatf("vhold%0d_gnt", i), pac_gnt, 0);
      chk($sformatf("vhold%0d_addr", i), ram_addr, 22);
      chk($sformatf("vhold%0d_we", i), ram_we, 0);
      if (i > 0) chk($sformatf("vhold%0d_vid", i), {vid_valid, vid_tile}, 3'b1_10);
    end
    @(posedge clk); #1 vid_req = 0;
    @(negedge clk);
    chk("vhold_gnt", pac_gnt, 1);
    chk("vhold_gnt_addr", ram_addr, 101);
    chk("vhold_last_vid", {vid_valid, vid_tile}, 3'b1_10);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (pac_done) begin ok = 1; tile = pac_tile; end
    end
    chk("vhold_done", ok, 1);
    chk("vhold_tile", tile, 1);
    @(posedge clk); #1 pac_req = 0;

    // vector table of Pac-Man transactions
    foreach (vt[i]) begin
      w0 = we_cnt; p0 = pe_cnt; q0 = pw_cnt;
      pac_txn(vt[i].x, vt[i].y, vt[i].eat, lat, tile, ga);
      chk($sformatf("v%0d_tile", i), tile, vt[i].tile);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_writes", i), we_cnt - w0, vt[i].wr);
      if (vt[i].wr != 0) chk($sformatf("v%0d_waddr", i), we_addr, vt[i].addr);
      if (vt[i].in_grid) chk($sformatf("v%0d_gaddr", i), ga, vt[i].addr);
      chk($sformatf("v%0d_pellet", i), pe_cnt - p0, vt[i].pe);
      chk($sformatf("v%0d_power", i), pw_cnt - q0, vt[i].pw);
    end
    chk("table_pellets", pellets_left, 297);

    // video during WB stalls the write for two cycles
    @(posedge clk); #1;
    pac_x = 40; pac_y = 16; pac_eat = 1; pac_req = 1;
    @(negedge clk);
    chk("wb_gnt", pac_gnt, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 vid_req = 1; vid_x = 8; vid_y = 40;
    @(negedge clk);
    chk("wb_stall0", {ram_we, ram_addr}, {1'b0, 10'd101});
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_stall1", {ram_we, ram_addr}, {1'b0, 10'd101});
    chk("wb_stall1_vid", {vid_valid, vid_tile}, 3'b1_01);
    @(posedge clk); #1 vid_req = 0;
    @(negedge clk);
    chk("wb_write", {ram_we, ram_addr, power_eaten, pellet_eaten}, {1'b1, 10'd45, 1'b1, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("wb_done", {pac_done, pac_tile}, 3'b1_11);
    @(posedge clk); #1 pac_req = 0; pac_eat = 0;
    @(negedge clk);
    chk("wb_pellets", pellets_left, 296);

    // video out of grid returns empty even though the wrapped address holds a wall
    @(posedge clk); #1 vid_req = 1; vid_x = 0; vid_y = 320;
    @(posedge clk); #1 vid_req = 0;
    @(negedge clk);
    chk("vid_oob", {vid_valid, vid_tile}, 3'b1_00);

    // counter bounds on the PELLET_TOTAL=2 instance
    do_reset();
    pac_txn(0, 80, 1, lat, tile, ga);
    chk("cnt_eat1_tile", tile, 2);
    chk("cnt_eat1_left", b_pellets_left, 1);
    pac_txn(8, 80, 1, lat, tile, ga);
    chk("cnt_eat2_tile", tile, 3);
    chk("cnt_eat2_left", b_pellets_left, 0);
    chk("cnt_clear", b_level_clear, 1);
    chk("cnt_big_left", {pellets_left, level_clear}, {10'd298, 1'b0});
    p0 = pe_cnt;
    pac_txn(16, 80, 1, lat, tile, ga);
    chk("cnt_sat_pulse", pe_cnt - p0, 1);
    chk("cnt_sat_left", b_pellets_left, 0);
    @(posedge clk); #1;
    pac_x = 24; pac_y = 80; pac_eat = 1; pac_req = 1;
    @(negedge clk);
    chk("ls_gnt", pac_gnt, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 level_start = 1;
    @(negedge clk);
    chk("ls_write", {ram_we, pellet_eaten}, 2'b11);
    @(posedge clk); #1 level_start = 0;
    @(negedge clk);
    chk("ls_done", pac_done, 1);
    chk("ls_b_left", b_pellets_left, 2);
    chk("ls_left", pellets_left, 300);
    @(posedge clk); #1 pac_req = 0; pac_eat = 0;
    @(negedge clk);
    chk("ls_clear", b_level_clear, 0);

    // reset in WAIT abandons the eat: no write, no done
    @(posedge clk); #1;
    pac_x = 32; pac_y = 80; pac_eat = 1; pac_req = 1;
    @(negedge clk);
    chk("rmid_gnt", pac_gnt, 1);
    w0 = we_cnt; ok = 0;
    @(posedge clk); #1 rst = 1; pac_req = 0; pac_eat = 0;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pac_done) ok++;
    end
    chk("rmid_no_write", we_cnt - w0, 0);
    chk("rmid_no_done", ok, 0);
    pac_txn(32, 80, 0, lat, tile, ga);
    chk("rmid_tile_kept", tile, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
